// File: rtl/yuv422to444_if.sv
`default_nettype none
// ============================================================================
//  Module      : nasti_stream_channel
//  Description : Stream channel bundle (valid/ready handshake with data,
//                strobe, keep, last and dest sidebands).
//  Revision    : 1.0 - initial release
// ============================================================================
interface nasti_stream_channel #(
  parameter int DATA_WIDTH = 64,
  parameter int DEST_WIDTH = 1
);
  logic                    t_valid;
  logic                    t_ready;
  logic [DATA_WIDTH-1:0]   t_data;
  logic [DATA_WIDTH/8-1:0] t_strb;
  logic [DATA_WIDTH/8-1:0] t_keep;
  logic                    t_last;
  logic [DEST_WIDTH-1:0]   t_dest;

  modport master (
    output t_valid, t_data, t_strb, t_keep, t_last, t_dest,
    input  t_ready
  );

  modport slave (
    input  t_valid, t_data, t_strb, t_keep, t_last, t_dest,
    output t_ready
  );
endinterface
`default_nettype wire

// File: rtl/yuv422to444.sv
`default_nettype none
// ============================================================================
//  Module      : yuv422to444
//  Description : YUYV 4:2:2 to packed 4:4:4 chroma upsampler. Each 64-bit
//                input beat (4 pixels) becomes two 64-bit output beats
//                (2 pixels each, pixel = {8'h00, Y, U, V}).
//                Optional macro YUV422_CHROMA_INTERP_EN: pixel1 chroma is the
//                round-half-up average of both chroma pairs instead of a copy.
//                Only DATA_WIDTH = 64 is supported.
//  Revision    : 1.0 - initial release
// ============================================================================
module yuv422to444 #(
  parameter int DATA_WIDTH = 64,
  parameter int DEST_WIDTH = 1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  nasti_stream_channel.slave   src,
  nasti_stream_channel.master  dst
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HALF = 2'd1;
  localparam logic [1:0] LAST = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  src_ready;
  logic                  src_hs;
  logic                  dst_hs;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [31:0]           hold_q;
  logic                  hold_last_q;

  logic [7:0]            y0, y1, u0, v0, u1_in, v1_in;
  logic [7:0]            p1_u, p1_v;
  logic [DATA_WIDTH-1:0] beat_a;
  logic [DATA_WIDTH-1:0] beat_b;

  assign src_hs = src.t_valid && src_ready;
  assign dst_hs = valid_q && dst.t_ready;

  // Unpack the lower pixel pair of the incoming beat (Y0 U0 Y1 V0 Y2 U1 Y3 V1)
  assign y0    = src.t_data[7:0];
  assign u0    = src.t_data[15:8];
  assign y1    = src.t_data[23:16];
  assign v0    = src.t_data[31:24];
  assign u1_in = src.t_data[47:40];
  assign v1_in = src.t_data[63:56];

`ifdef YUV422_CHROMA_INTERP_EN
  // Pixel1 sits between the two chroma sites, so blend them (9-bit sum, round up)
  assign p1_u = 8'(({1'b0, u0} + {1'b0, u1_in} + 9'd1) >> 1);
  assign p1_v = 8'(({1'b0, v0} + {1'b0, v1_in} + 9'd1) >> 1);
`else
  assign p1_u = u0;
  assign p1_v = v0;
`endif

  assign beat_a = {8'h00, y1, p1_u, p1_v, 8'h00, y0, u0, v0};
  // hold_q = {V1, Y3, U1, Y2}
  assign beat_b = {8'h00, hold_q[23:16], hold_q[15:8], hold_q[31:24],
                   8'h00, hold_q[7:0],   hold_q[15:8], hold_q[31:24]};

  // State register
  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (src_hs) state_d = HALF;
      HALF:    if (dst_hs) state_d = LAST;
      LAST:    if (dst_hs) state_d = src.t_valid ? HALF : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Input acceptance: free in IDLE, blocked in HALF, chained to dst in LAST
  always_comb begin
    src_ready = 1'b0;
    case (state_q)
      IDLE:    src_ready = 1'b1;
      HALF:    src_ready = 1'b0;
      LAST:    src_ready = dst.t_ready;
      default: src_ready = 1'b0;
    endcase
  end

  // Output register next values: load A on accept, B after A drains, else hold
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (src_hs) begin
      data_d  = beat_a;
      valid_d = 1'b1;
      last_d  = 1'b0;
    end else if ((state_q == HALF) && dst_hs) begin
      data_d  = beat_b;
      last_d  = hold_last_q;
    end else if ((state_q == LAST) && dst_hs) begin
      valid_d = 1'b0;
    end
  end

  // Control outputs that must come out of reset in a known state
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  // Payload and upper-half hold register; contents are irrelevant while invalid
  always_ff @(posedge aclk) begin
    data_q <= data_d;
    if (src_hs) begin
      hold_q      <= src.t_data[63:32];
      hold_last_q <= src.t_last;
    end
  end

`ifndef SYNTHESIS
  // Partial beats are not handled; flag them and process as full
  always_ff @(posedge aclk) begin
    if (aresetn && src_hs && ((src.t_keep != '1) || (src.t_strb != '1)))
      $error("Null byte not supported");
  end
`endif

  assign src.t_ready = src_ready;
  assign dst.t_valid = valid_q;
  assign dst.t_data  = data_q;
  assign dst.t_last  = last_q;
  assign dst.t_strb  = '1;
  assign dst.t_keep  = '1;
  assign dst.t_dest  = {DEST_WIDTH{1'b0}};

endmodule
`default_nettype wire

// File: tb/tb_yuv422to444.sv
`default_nettype none
// ============================================================================
//  Module      : tb_yuv422to444
//  Description : Scoreboard bench for yuv422to444 with directed and random
//                stimulus against a pixel-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_yuv422to444;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } exp_t;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;

  nasti_stream_channel #(.DATA_WIDTH(64), .DEST_WIDTH(1)) src_if ();
  nasti_stream_channel #(.DATA_WIDTH(64), .DEST_WIDTH(1)) dst_if ();

  yuv422to444 #(.DATA_WIDTH(64), .DEST_WIDTH(1)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .src     (src_if),
    .dst     (dst_if)
  );

  always #5 aclk = ~aclk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_cnt  = 0;
  exp_t exp_q[$];
  int   stamps[$];
  bit   ready_mode   = 1'b0;
  bit   forced_ready = 1'b1;

  localparam logic [63:0] DIR_WORD = 64'hA0407030_90208010;
`ifdef YUV422_CHROMA_INTERP_EN
  localparam logic [63:0] DIR_A = 64'h00207898_00108090;
`else
  localparam logic [63:0] DIR_A = 64'h00208090_00108090;
`endif
  localparam logic [63:0] DIR_B = 64'h004070A0_003070A0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Reference: split the beat into Y[4], U[2], V[2] and rebuild pixels
  function automatic logic [63:0] model_beat(input logic [63:0] d, input int which);
    int y[4];
    int u[2];
    int v[2];
    int p, uc, vc;
    logic [63:0] r;
    for (int i = 0; i < 4; i++) y[i] = int'(d[16*i +: 8]);
    for (int j = 0; j < 2; j++) begin
      u[j] = int'(d[32*j+8 +: 8]);
      v[j] = int'(d[32*j+24 +: 8]);
    end
    r = '0;
    for (int k = 0; k < 2; k++) begin
      p  = 2 * which + k;
      uc = u[p / 2];
      vc = v[p / 2];
`ifdef YUV422_CHROMA_INTERP_EN
      if (p == 1) begin
        uc = (u[0] + u[1] + 1) / 2;
        vc = (v[0] + v[1] + 1) / 2;
      end
`endif
      r[32*k +: 32] = {8'h00, 8'(y[p]), 8'(uc), 8'(vc)};
    end
    return r;
  endfunction

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  // Offer one beat; expected outputs are queued at the handshake
  task automatic send_beat(input logic [63:0] d, input logic l, input bit use_const,
                           input logic [63:0] ea, input logic [63:0] eb, output int waits);
    bit done;
    exp_t e;
    done  = 1'b0;
    waits = 0;
    src_if.t_valid = 1'b1;
    src_if.t_data  = d;
    src_if.t_last  = l;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge aclk);
      waits++;
      if (src_if.t_ready) begin
        e.data = use_const ? ea : model_beat(d, 0);
        e.last = 1'b0;
        exp_q.push_back(e);
        e.data = use_const ? eb : model_beat(d, 1);
        e.last = l;
        exp_q.push_back(e);
        done = 1'b1;
      end
      cyc();
    end
    src_if.t_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: src beat %h not accepted within 200 cycles", d);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) cyc();
    repeat (2) cyc();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // dst ready driver
  initial begin
    forever begin
      @(posedge aclk);
      #2;
      dst_if.t_ready = ready_mode ? ($urandom_range(0, 3) != 0) : forced_ready;
    end
  end

  // Monitor: pops the scoreboard on every dst handshake, checks stall stability
  initial begin
    bit          prev_stall;
    logic [63:0] prev_data;
    logic        prev_last;
    exp_t        e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge aclk);
      cyc_cnt++;
      if (!aresetn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 64'(dst_if.t_valid), 64'd1);
          chk("stall_data", dst_if.t_data, prev_data);
          chk("stall_last", 64'(dst_if.t_last), 64'(prev_last));
        end
        if (dst_if.t_valid && dst_if.t_ready) begin
          stamps.push_back(cyc_cnt);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got %h last %0b, expected no beat",
                     dst_if.t_data, dst_if.t_last);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", dst_if.t_data, e.data);
            chk("beat_last", 64'(dst_if.t_last), 64'(e.last));
            chk("sideband", 64'({dst_if.t_strb, dst_if.t_keep, dst_if.t_dest}),
                64'({8'hFF, 8'hFF, 1'b0}));
          end
        end
        prev_stall = dst_if.t_valid && !dst_if.t_ready;
        prev_data  = dst_if.t_data;
        prev_last  = dst_if.t_last;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    src_if.t_valid = 1'b0;
    src_if.t_data  = '0;
    src_if.t_last  = 1'b0;
    src_if.t_strb  = '1;
    src_if.t_keep  = '1;
    src_if.t_dest  = '0;

    // Reset state
    repeat (3) cyc();
    aresetn = 1'b1;
    @(negedge aclk);
    chk("reset_dst_valid", 64'(dst_if.t_valid), 64'd0);
    chk("reset_dst_last", 64'(dst_if.t_last), 64'd0);
    chk("reset_src_ready", 64'(src_if.t_ready), 64'd1);
    cyc();

    // Directed replication / interpolation vector, then t_last propagation
    send_beat(DIR_WORD, 1'b0, 1'b1, DIR_A, DIR_B, w);
    drain();
    send_beat(DIR_WORD, 1'b1, 1'b1, DIR_A, DIR_B, w);
    drain();

    // Back-to-back: 4 beats -> 8 contiguous output beats
    stamps.delete();
    for (int b = 0; b < 4; b++) begin
      send_beat({$urandom, $urandom}, 1'(b == 3), 1'b0, '0, '0, w);
      chk("b2b_src_ready_wait", 64'(w), (b == 0) ? 64'd1 : 64'd2);
    end
    drain();
    chk("b2b_count", 64'(stamps.size()), 64'd8);
    for (int k = 1; k < stamps.size(); k++)
      chk("b2b_no_bubble", 64'(stamps[k]), 64'(stamps[k-1] + 1));

    // Backpressure while beat A is valid
    forced_ready = 1'b0;
    cyc();
    send_beat({$urandom, $urandom}, 1'b1, 1'b0, '0, '0, w);
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      chk("bp_dst_valid", 64'(dst_if.t_valid), 64'd1);
      chk("bp_src_ready", 64'(src_if.t_ready), 64'd0);
      cyc();
    end
    stamps.delete();
    forced_ready = 1'b1;
    drain();
    chk("bp_count", 64'(stamps.size()), 64'd2);
    if (stamps.size() == 2)
      chk("bp_beat_b_next", 64'(stamps[1]), 64'(stamps[0] + 1));

    // Reset while in HALF discards the held beat B
    forced_ready = 1'b0;
    cyc();
    send_beat({$urandom, $urandom}, 1'b0, 1'b0, '0, '0, w);
    aresetn = 1'b0;
    cyc();
    aresetn = 1'b1;
    exp_q.delete();
    @(negedge aclk);
    chk("rst_half_dst_valid", 64'(dst_if.t_valid), 64'd0);
    chk("rst_half_src_ready", 64'(src_if.t_ready), 64'd1);
    cyc();
    forced_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      chk("rst_no_output", 64'(dst_if.t_valid), 64'd0);
      cyc();
    end

    // Random traffic with random backpressure
    ready_mode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 1)) cyc();
      send_beat({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0, '0, '0, w);
    end
    ready_mode   = 1'b0;
    forced_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
